// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, opcodes, flag indices and sequencer states
package alu_pkg;

    // Function select presented to the external ALU
    typedef enum logic [2:0] {
        ALU_SUM = 3'b000,
        ALU_OR  = 3'b001,
        ALU_XOR = 3'b010,
        ALU_AND = 3'b011,
        ALU_SR  = 3'b100
    } alu_ctrl_e;

    // Request opcodes; 10..15 behave as NOP
    typedef enum logic [3:0] {
        OP_ADC = 4'd0,
        OP_SBC = 4'd1,
        OP_AND = 4'd2,
        OP_ORA = 4'd3,
        OP_EOR = 4'd4,
        OP_CMP = 4'd5,
        OP_ASL = 4'd6,
        OP_ROL = 4'd7,
        OP_LSR = 4'd8,
        OP_ROR = 4'd9,
        OP_NOP = 4'd10
    } op_e;

    // Bit positions inside the {N,V,Z,C} flag vector
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ADJ  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Signed overflow of a + b giving r: operands agree in sign, result differs
    function automatic logic add_ovf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
        return ~(a[7] ^ b[7]) & (a[7] ^ r[7]);
    endfunction

endpackage

// File: rtl/bcd_corr.sv
// rtl/bcd_corr.sv - decimal correction constant and carry for BCD add/subtract
// Ports: temp/co/hc = binary sum and its carries from the first pass,
//        is_sub = subtract mode; corr = value to add in the second pass,
//        c_out = final decimal carry.
module bcd_corr (
    input  logic [7:0] temp,
    input  logic       co,
    input  logic       hc,
    input  logic       is_sub,
    output logic [7:0] corr,
    output logic       c_out
);

    logic gt99;
    assign gt99 = (temp > 8'h99);

    always_comb begin
        corr  = 8'h00;
        c_out = co;
        if (is_sub) begin
            // Subtracting 6 / 0x60 is done as adding 0xFA / 0xA0; the sum wraps mod 256
            corr = (hc ? 8'h00 : 8'hFA) + (co ? 8'h00 : 8'hA0);
        end else begin
            corr  = (((temp[3:0] > 4'd9) || hc) ? 8'h06 : 8'h00)
                  + ((gt99 || co) ? 8'h60 : 8'h00);
            c_out = co | gt99;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencer driving an external 8-bit ALU with binary and BCD ops
// Ports: clk/rst (sync, active high); req_valid/req_ready/req_op/req_operand/d_flag
//        request; acc_ld/acc_din, p_ld/p_din register loads (IDLE only);
//        acc, flags {N,V,Z,C}, done status; alu_* drive and observe the ALU.
module alu_seq
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_operand,
    input  logic       d_flag,
    input  logic       acc_ld,
    input  logic [7:0] acc_din,
    input  logic       p_ld,
    input  logic [3:0] p_din,
    output logic [7:0] acc,
    output logic [3:0] flags,
    output logic       done,
    output logic [2:0] alu_ctrl,
    output logic [7:0] alu_ai,
    output logic [7:0] alu_bi,
    output logic       alu_ci,
    output logic       alu_daa,
    input  logic [7:0] alu_y,
    input  logic       alu_co,
    input  logic       alu_hc
);

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] opnd_q, opnd_d;
    logic       dec_q, dec_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] flags_q, flags_d;
    logic [7:0] temp_q, temp_d;
    logic       tco_q, tco_d;
    logic       thc_q, thc_d;

    logic [7:0] corr;
    logic       corr_c;
    logic [7:0] b_eff;
    logic       c_in;
    logic       dec_arith;

    assign b_eff     = (op_q == OP_SBC) ? ~opnd_q : opnd_q;
    assign c_in      = flags_q[FLAG_C];
    assign dec_arith = dec_q && ((op_q == OP_ADC) || (op_q == OP_SBC));

    bcd_corr u_bcd_corr (
        .temp   (temp_q),
        .co     (tco_q),
        .hc     (thc_q),
        .is_sub (op_q == OP_SBC),
        .corr   (corr),
        .c_out  (corr_c)
    );

    assign acc       = acc_q;
    assign flags     = flags_q;
    assign done      = (state_q == ST_DONE);
    assign req_ready = (state_q == ST_IDLE);
    assign alu_daa   = 1'b0;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        dec_d    = dec_q;
        acc_d    = acc_q;
        flags_d  = flags_q;
        temp_d   = temp_q;
        tco_d    = tco_q;
        thc_d    = thc_q;
        alu_ctrl = ALU_SUM;
        alu_ai   = 8'h00;
        alu_bi   = 8'h00;
        alu_ci   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc_ld) acc_d   = acc_din;
                if (p_ld)   flags_d = p_din;
                if (req_valid) begin
                    op_d    = req_op;
                    opnd_d  = req_operand;
                    dec_d   = d_flag;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (op_q)
                    OP_ADC: begin alu_ai = acc_q; alu_bi = opnd_q;  alu_ci = c_in; end
                    OP_SBC: begin alu_ai = acc_q; alu_bi = ~opnd_q; alu_ci = c_in; end
                    OP_CMP: begin alu_ai = acc_q; alu_bi = ~opnd_q; alu_ci = 1'b1; end
                    OP_AND: begin alu_ctrl = ALU_AND; alu_ai = acc_q; alu_bi = opnd_q; end
                    OP_ORA: begin alu_ctrl = ALU_OR;  alu_ai = acc_q; alu_bi = opnd_q; end
                    OP_EOR: begin alu_ctrl = ALU_XOR; alu_ai = acc_q; alu_bi = opnd_q; end
                    OP_ASL: begin alu_ai = acc_q; alu_bi = acc_q; end
                    OP_ROL: begin alu_ai = acc_q; alu_bi = acc_q; alu_ci = c_in; end
                    OP_LSR: begin alu_ctrl = ALU_SR; alu_ai = acc_q; end
                    OP_ROR: begin alu_ctrl = ALU_SR; alu_ai = acc_q; alu_ci = c_in; end
                    default: ;
                endcase

                temp_d = alu_y;
                tco_d  = alu_co;
                thc_d  = alu_hc;

                if (dec_arith) begin
                    state_d = ST_ADJ;
                end else begin
                    state_d = ST_DONE;
                    // Binary results commit here so they appear with the done pulse
                    case (op_q)
                        OP_ADC, OP_SBC: begin
                            acc_d           = alu_y;
                            flags_d[FLAG_N] = alu_y[7];
                            flags_d[FLAG_Z] = (alu_y == 8'h00);
                            flags_d[FLAG_C] = alu_co;
                            flags_d[FLAG_V] = add_ovf(acc_q, b_eff, alu_y);
                        end
                        OP_CMP: begin
                            flags_d[FLAG_N] = alu_y[7];
                            flags_d[FLAG_Z] = (alu_y == 8'h00);
                            flags_d[FLAG_C] = alu_co;
                        end
                        OP_AND, OP_ORA, OP_EOR: begin
                            acc_d           = alu_y;
                            flags_d[FLAG_N] = alu_y[7];
                            flags_d[FLAG_Z] = (alu_y == 8'h00);
                        end
                        OP_ASL, OP_ROL, OP_LSR, OP_ROR: begin
                            acc_d           = alu_y;
                            flags_d[FLAG_N] = alu_y[7];
                            flags_d[FLAG_Z] = (alu_y == 8'h00);
                            flags_d[FLAG_C] = alu_co;
                        end
                        default: ;
                    endcase
                end
            end

            ST_ADJ: begin
                // Second ALU pass adds the decimal correction to the binary sum
                alu_ctrl        = ALU_SUM;
                alu_ai          = temp_q;
                alu_bi          = corr;
                acc_d           = alu_y;
                flags_d[FLAG_N] = alu_y[7];
                flags_d[FLAG_Z] = (alu_y == 8'h00);
                flags_d[FLAG_C] = corr_c;
                // Overflow follows the binary first pass, acc_q still holds the old value
                flags_d[FLAG_V] = add_ovf(acc_q, b_eff, temp_q);
                state_d         = ST_DONE;
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 4'h0;
            opnd_q  <= 8'h00;
            dec_q   <= 1'b0;
            acc_q   <= 8'h00;
            flags_q <= 4'h0;
            temp_q  <= 8'h00;
            tco_q   <= 1'b0;
            thc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            dec_q   <= dec_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            temp_q  <= temp_d;
            tco_q   <= tco_d;
            thc_q   <= thc_d;
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: req_valid  in  1  op request; req_ready  out  1  high only in IDLE; req_op  in  4  opcode (0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 ASL, 7 ROL, 8 LSR, 9 ROR, 10-15 NOP); req_operand  in  8  memory operand.
REQ-003 SHALL have ports: d_flag  in  1  decimal mode, sampled at accept; acc_ld  in  1  accumulator load strobe; acc_din  in  8  load data; p_ld  in  1  flag load strobe; p_din  in  4  {N,V,Z,C} load data.
REQ-004 SHALL have ports: acc  out  8  accumulator; flags  out  4  {N,V,Z,C}; done  out  1  one-cycle completion pulse.
REQ-005 SHALL have ALU-facing ports: alu_ctrl  out  3  (SUM 000, OR 001, XOR 010, AND 011, SR 100); alu_ai  out  8; alu_bi  out  8; alu_ci  out  1; alu_daa  out  1, tied 0; alu_y  in  8; alu_co  in  1; alu_hc  in  1.

Function
REQ-006 SHALL implement FSM IDLE -> EXEC -> (ADJ) -> DONE -> IDLE.
REQ-007 IDLE: req_ready=1; req_valid&&req_ready latches op, operand, d_flag; next EXEC.
REQ-008 EXEC: drives ALU from latched op and current acc/C; captures alu_y/alu_co/alu_hc into temp regs; next ADJ if decimal ADC/SBC, else DONE.
REQ-009 Op mapping: ADC SUM(acc, opnd, C); SBC and CMP SUM(acc, ~opnd, C for SBC / 1 for CMP); AND/ORA/EOR AND/OR/XOR(acc, opnd); ASL SUM(acc, acc, 0); ROL SUM(acc, acc, C); LSR SR(acc, -, 0); ROR SR(acc, -, C).
REQ-010 ADJ (decimal only): drives SUM(temp, corr, 0); ADC corr = (lo nibble>9 or hc ? 0x06 : 0) + (temp>0x99 or co ? 0x60 : 0); SBC corr = (!hc ? 0xFA : 0) + (!co ? 0xA0 : 0), mod 256.
REQ-011 Registers SHALL update on the EXEC/ADJ -> DONE transition; done=1 for exactly the DONE cycle; binary ops: done 2 cycles after accept; decimal: 3.
REQ-012 N = result[7], Z = (result==0), both computed in this block from captured alu_y, never from ALU N/Z outputs.
REQ-013 C = alu_co from EXEC, except decimal ADC: C = co OR (temp>0x99).
REQ-014 V only for ADC/SBC = bit7 of (~(acc^B) & (acc^temp)), B = opnd or ~opnd, from EXEC result; all other ops leave V unchanged.
REQ-015 AND/ORA/EOR: C unchanged; CMP: N,Z,C updated, acc unchanged; NOP: nothing updated, done still pulses.
REQ-016 acc_ld/p_ld honored only in IDLE; ignored elsewhere; if asserted with accept, load occurs and EXEC uses loaded values.
REQ-017 req_valid outside IDLE SHALL be ignored (no queuing).

Reset
REQ-018 rst in any state SHALL force IDLE, acc=0x00, flags=0000, done=0, temps=0, req_ready=1 the following cycle; an in-flight op is discarded without register update.
REQ-019 In IDLE/DONE ALU outputs SHALL be alu_ctrl=000, alu_ai=alu_bi=0, alu_ci=0.

Structure
REQ-020 Shared package alu_pkg SHALL hold ALU ctrl codes, the 4-bit opcode enum and the flag bit indices.
REQ-021 BCD correction (REQ-010/013) SHALL be sub-module bcd_corr (combinational: temp, co, hc, is_sub -> corr, c_out).
REQ-022 Bench SHALL pair alu_seq with the existing ALU model; ALU Z/N outputs unconnected.

Verification
REQ-023 acc=0x50, C=0, ADC 0x50, D=0 -> acc=0xA0, N=1 V=1 Z=0 C=0, done at accept+2.
REQ-024 acc=0x99, C=0, ADC 0x01, D=1 -> acc=0x00, C=1, Z=1, done at accept+3; acc=0x19 ADC 0x28 D=1 -> acc=0x47, C=0.
REQ-025 acc=0x42, C=1, SBC 0x13, D=1 -> acc=0x29, C=1.
REQ-026 acc=0x10, CMP 0x20 -> acc=0x10, C=0 N=1 Z=0; acc=0x01 C=1 ROR -> acc=0x80 C=1 N=1; acc=0x80 ASL -> acc=0x00 C=1 Z=1.
REQ-027 Accept ADC, assert rst in EXEC -> next cycle IDLE, acc=0x00, flags=0, no done pulse; req_valid held through op -> second op accepted only after DONE.
